// File: rtl/arith_pkg.sv
// arith_pkg
// Shared definitions for the arithmetic unit and its writeback sequencer:
// opcode encodings, the sequencer state type, the flag bundle and the
// result pattern the divider emits for a zero divisor.
// Ports: none (package).
package arith_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    localparam logic [31:0] DIV_ZERO_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

    typedef struct packed {
        logic z;
        logic ovf;
        logic dz;
        logic ill;
    } wb_flags_t;

    // Illegal opcode: top opcode bit set.
    function automatic logic is_illegal(input logic [2:0] opcode);
        return opcode[2];
    endfunction

endpackage

// File: rtl/arith_wb_seq_if.sv
// arith_wb_seq_if
// Bundles the result handshake, register-file write port and status outputs
// of the writeback sequencer.
// Ports (signals):
//   in_valid/in_ready    result handshake
//   in_opcode/in_result/in_rd  transaction payload
//   wb_en/wb_addr/wb_data      register-file write port
//   done, flag_z/ovf/dz/ill    completion pulse and latched status
// Modports: master (producer / observer side), slave (sequencer side).
interface arith_wb_seq_if #(
    parameter int REG_AW = 3,
    parameter int DW     = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_opcode;
    logic [2*DW-1:0]     in_result;
    logic [REG_AW-1:0]   in_rd;
    logic                wb_en;
    logic [REG_AW-1:0]   wb_addr;
    logic [DW-1:0]       wb_data;
    logic                done;
    logic                flag_z;
    logic                flag_ovf;
    logic                flag_dz;
    logic                flag_ill;

    modport master (
        output in_valid, in_opcode, in_result, in_rd,
        input  in_ready, wb_en, wb_addr, wb_data, done,
               flag_z, flag_ovf, flag_dz, flag_ill
    );

    modport slave (
        input  in_valid, in_opcode, in_result, in_rd,
        output in_ready, wb_en, wb_addr, wb_data, done,
               flag_z, flag_ovf, flag_dz, flag_ill
    );

endinterface

// File: rtl/arith_flag_gen.sv
// arith_flag_gen
// Combinational map from (opcode, result) to the status flags.
// Ports:
//   opcode  in  3      arithmetic opcode
//   result  in  2*DW   arithmetic result
//   flags   out 4      {z, ovf, dz, ill}
module arith_flag_gen
    import arith_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [2:0]      opcode,
    input  logic [2*DW-1:0] result,
    output wb_flags_t       flags
);

    logic ill;
    logic dz;

    always_comb begin
        ill       = is_illegal(opcode);
        // The divider signals a zero divisor by returning all ones.
        dz        = (opcode == OP_DIV) && (&result);
        flags.ill = ill;
        flags.dz  = dz;
        flags.ovf = (opcode == OP_MUL) && (result[2*DW-1:DW] != '0);
        flags.z   = (result == '0) && !dz && !ill;
    end

endmodule

// File: rtl/arith_wb_seq.sv
// arith_wb_seq
// Writeback sequencer: accepts one 2*DW-bit result per transaction and
// writes it into a DW-bit register file one word per cycle, then pulses done
// with latched status flags.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   bus    arith_wb_seq_if.slave (handshake, write port, done, flags)
// Build option: ARITH_WB_HI_EN -- when defined, MUL also writes the high
// word to rd+1 (wrapping); otherwise only the low word is written.
//
// state | meaning
// IDLE  | ready for a result
// WR_LO | writing low word to rd
// WR_HI | writing high word to rd+1 (MUL, ARITH_WB_HI_EN only)
// DONE  | completion pulse, flags just updated
module arith_wb_seq
    import arith_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int DW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    arith_wb_seq_if.slave bus
);

    wb_state_t         state;
    wb_state_t         state_nxt;
    logic [2:0]        op_q;
    logic [2*DW-1:0]   res_q;
    logic [REG_AW-1:0] rd_q;
    wb_flags_t         flags_q;
    wb_flags_t         flags_cur;
    logic              accept;
    logic [2:0]        op_src;
    logic [2*DW-1:0]   res_src;

    assign accept = bus.in_valid && (state == IDLE);

    // No-write transactions reach DONE on the accept edge, before the payload
    // registers hold the new value, so the flag generator looks at the live
    // inputs while idle.
    assign op_src  = (state == IDLE) ? bus.in_opcode : op_q;
    assign res_src = (state == IDLE) ? bus.in_result : res_q;

    arith_flag_gen #(.DW(DW)) u_flag_gen (
        .opcode (op_src),
        .result (res_src),
        .flags  (flags_cur)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= '0;
            res_q   <= '0;
            rd_q    <= '0;
            flags_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= bus.in_opcode;
                res_q <= bus.in_result;
                rd_q  <= bus.in_rd;
            end
            if ((state_nxt == DONE) && (state != DONE)) begin
                flags_q <= flags_cur;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (flags_cur.dz || flags_cur.ill) ? DONE : WR_LO;
                end
            end
            WR_LO: begin
`ifdef ARITH_WB_HI_EN
                state_nxt = (op_q == OP_MUL) ? WR_HI : DONE;
`else
                state_nxt = DONE;
`endif
            end
`ifdef ARITH_WB_HI_EN
            WR_HI: state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        bus.wb_en    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.done     = 1'b0;
        case (state)
            IDLE: bus.in_ready = 1'b1;
            WR_LO: begin
                bus.wb_en   = 1'b1;
                bus.wb_addr = rd_q;
                bus.wb_data = res_q[DW-1:0];
            end
`ifdef ARITH_WB_HI_EN
            WR_HI: begin
                bus.wb_en   = 1'b1;
                bus.wb_addr = rd_q + REG_AW'(1);
                bus.wb_data = res_q[2*DW-1:DW];
            end
`endif
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.flag_z   = flags_q.z;
    assign bus.flag_ovf = flags_q.ovf;
    assign bus.flag_dz  = flags_q.dz;
    assign bus.flag_ill = flags_q.ill;

endmodule

// File: tb/tb_arith_wb_seq.sv
// tb_arith_wb_seq
// Scoreboard bench for arith_wb_seq: the driver predicts writes, completion
// cycle and flags for every accepted transaction; a negedge monitor compares
// the DUT outputs against those predictions cycle by cycle.
module tb_arith_wb_seq;
    import arith_pkg::*;

    localparam int AW = 3;
    localparam int DW = 16;
`ifdef ARITH_WB_HI_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int         cyc;
        logic [3:0] flags;
    } dn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arith_wb_seq_if #(.REG_AW(AW), .DW(DW)) bus ();

    arith_wb_seq #(.REG_AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    wr_t  wq[$];
    dn_t  dq[$];
    logic [3:0] cur_flags = 4'b0;
    int   acc_e  = -10;
    int   done_d = -10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: cyc here counts rising edges seen so far.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            logic exp_we;
            logic exp_dn;
            while (wq.size() > 0 && wq[0].cyc < cyc) void'(wq.pop_front());
            while (dq.size() > 0 && dq[0].cyc < cyc) void'(dq.pop_front());
            exp_we = (wq.size() > 0) && (wq[0].cyc == cyc);
            exp_dn = (dq.size() > 0) && (dq[0].cyc == cyc);
            chk("wb_en", 32'(bus.wb_en), 32'(exp_we));
            if (exp_we) begin
                chk("wb_addr", 32'(bus.wb_addr), 32'(wq[0].addr));
                chk("wb_data", 32'(bus.wb_data), 32'(wq[0].data));
                void'(wq.pop_front());
            end else begin
                chk("idle_addr", 32'(bus.wb_addr), 32'd0);
                chk("idle_data", 32'(bus.wb_data), 32'd0);
            end
            chk("done", 32'(bus.done), 32'(exp_dn));
            if (exp_dn) begin
                cur_flags = dq[0].flags;
                void'(dq.pop_front());
            end
            chk("flags", 32'({bus.flag_z, bus.flag_ovf, bus.flag_dz, bus.flag_ill}), 32'(cur_flags));
            if (rst_n) chk("in_ready", 32'(bus.in_ready), 32'(!(cyc > acc_e && cyc <= done_d)));
        end
    end

    // Reference model: predicts the effect of a transaction accepted on the
    // edge following negedge cycle e.
    task automatic predict(input int e, input logic [2:0] op, input logic [31:0] res, input logic [2:0] rd);
        logic ill, dz, z, ovf;
        int   k;
        wr_t  w;
        dn_t  d;
        ill = op[2];
        dz  = (op == OP_DIV) && (res == DIV_ZERO_RESULT);
        z   = (res == 32'd0) && !ill && !dz;
        ovf = (op == OP_MUL) && (res[31:16] != 16'd0);
        k = 0;
        if (!ill && !dz) begin
            w.cyc = e + 1; w.addr = rd; w.data = res[15:0];
            wq.push_back(w);
            k = 1;
            if (HI_EN && op == OP_MUL) begin
                w.cyc = e + 2; w.addr = 3'((int'(rd) + 1) % 8); w.data = res[31:16];
                wq.push_back(w);
                k = 2;
            end
        end
        d.cyc = e + 1 + k;
        d.flags = {z, ovf, dz, ill};
        dq.push_back(d);
        acc_e  = e;
        done_d = e + 1 + k;
    endtask

    // Presents a transaction and leaves in_valid high after it is accepted.
    task automatic send(input logic [2:0] op, input logic [31:0] res, input logic [2:0] rd);
        int n;
        @(negedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_result = res;
        bus.in_rd     = rd;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout cyc=%0d got=in_ready_low want=in_ready_high", cyc);
            return;
        end
        predict(cyc, op, res, rd);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        @(negedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.in_opcode = 3'($urandom);
        bus.in_result = $urandom;
        bus.in_rd     = 3'($urandom);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] res;
        bus.in_valid  = 1'b0;
        bus.in_opcode = 3'd0;
        bus.in_result = 32'd0;
        bus.in_rd     = 3'd0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        send(OP_ADD, 32'h0000_1234, 3'd2);  idle(4);
        send(OP_SUB, 32'h0000_0000, 3'd5);  idle(4);
        send(OP_MUL, 32'h0001_E240, 3'd7);  idle(4);
        send(OP_DIV, DIV_ZERO_RESULT, 3'd1); idle(4);
        send(3'b101, 32'h0000_00AA, 3'd3);  idle(4);
        send(OP_DIV, 32'h0000_0007, 3'd4);  idle(4);

        // Valid held high across several back-to-back transactions.
        send(OP_ADD, 32'h0000_BEEF, 3'd6);
        send(OP_ADD, 32'h0000_BEEF, 3'd6);
        send(OP_MUL, 32'hFFFF_0001, 3'd0);
        idle(4);

        // Reset during the low-word write of a MUL.
        send(OP_MUL, 32'h0001_E240, 3'd7);
        @(negedge clk); #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        wq.delete();
        dq.delete();
        cur_flags = 4'b0;
        acc_e  = -10;
        done_d = -10;
        @(negedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) op = 3'($urandom_range(4, 7));
            else op = 3'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: res = 32'd0;
                1: res = DIV_ZERO_RESULT;
                2: res = {16'd0, 16'($urandom)};
                3: res = $urandom;
                default: res = {16'($urandom_range(1, 3)), 16'($urandom)};
            endcase
            send(op, res, 3'($urandom));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
        end
        idle(10);

        chk("writes_drained", 32'(wq.size()), 32'd0);
        chk("dones_drained", 32'(dq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arith_wb_seq.md
# arith_wb_seq

- Writeback sequencer directly downstream of the CPU's combinational arithmetic unit.
- Accepts one 32-bit arithmetic result per transaction over a valid/ready handshake, together with its opcode and destination register.
- Writes the result into the 16-bit register file through that file's single write port, one word per cycle.
- Produces status flags and a one-cycle completion pulse for the control FSM.

## Interface
Parameters:
- REG_AW, default 3: register-file address width (8 registers).
- DW, default 16: register data width. Result width is 2*DW.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- in_valid, input, 1: result, opcode and destination are valid.
- in_ready, output, 1: sequencer can accept; high only in IDLE.
- in_opcode, input, 3: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 1xx illegal.
- in_result, input, 2*DW: arithmetic result.
- in_rd, input, REG_AW: destination register.
- wb_en, output, 1: register-file write strobe.
- wb_addr, output, REG_AW: write address.
- wb_data, output, DW: write data.
- done, output, 1: one-cycle pulse at end of every transaction.
- flag_z, output, 1: latched result == 0.
- flag_ovf, output, 1: latched MUL high word nonzero.
- flag_dz, output, 1: latched DIV by zero (in_result == all ones on DIV).
- flag_ill, output, 1: latched illegal opcode.

## Operation
- States: IDLE, WR_LO, WR_HI, DONE.
- Accept occurs when in_valid && in_ready. On accept, latch opcode, result and rd into internal registers.
- Transitions from IDLE on accept:
  - ADD, SUB, non-zero DIV: go to WR_LO.
  - MUL: go to WR_LO.
  - DIV with in_result == 32'hFFFF_FFFF: go directly to DONE, no write.
  - Illegal opcode: go directly to DONE, no write.
- WR_LO:
  - wb_en=1, wb_addr=rd, wb_data=result[15:0].
  - Next state is WR_HI for MUL when ARITH_WB_HI_EN is defined, otherwise DONE.
- WR_HI:
  - wb_en=1, wb_data=result[31:16], wb_addr=rd+1 modulo 2^REG_AW (rd=7 wraps to 0).
  - Next state is DONE.
- DONE: done=1. Flags update on entry to DONE and hold until the next entry. Next state is IDLE.
- Flag rules:
  - flag_z = (latched 32-bit result == 0), except 0 on dz or ill.
  - flag_ovf = MUL && result[31:16] != 0.
  - flag_dz and flag_ill are as defined in Interface.
- Inputs are ignored outside IDLE. in_valid held high during a transaction is not re-accepted until IDLE.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1 in IDLE. wb_en=0, wb_addr=0, wb_data=0, done=0, all flags=0.
- Outputs are Moore, decoded from state and latched registers. No input-to-output combinational path except none; in_ready depends on state only.
- Latency from accept edge E:
  - 1-word transaction: wb_en in cycle E+1, done in E+2, in_ready high in E+3.
  - MUL with high word: wb_en in E+1 and E+2, done in E+3.
  - No-write transaction: done in E+1.
- Throughput: one transaction per 3 cycles (4 for MUL with high word).
- wb_en is never high in IDLE or DONE. wb_addr and wb_data are 0 when wb_en=0.
- Reset asserted mid-transaction: the next edge forces IDLE and clears all outputs and flags. Any pending write is dropped with no partial high-word write.

## Configuration
- ARITH_WB_HI_EN defined: MUL writes the full 32-bit product to the register pair rd, rd+1 via WR_HI. flag_ovf is still reported.
- ARITH_WB_HI_EN undefined: WR_HI state is removed. MUL writes only the low word; flag_ovf is the sole indication of truncation.

## Structure
- Shared package arith_pkg holds:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - state enum wb_state_t;
  - DIV_ZERO_RESULT = 32'hFFFF_FFFF.
- The arithmetic unit uses the same opcode constants from arith_pkg.
- One combinational sub-module, arith_flag_gen, maps (opcode, result) to the z/ovf/dz/ill flags. The sequencer registers its outputs on entry to DONE.

## Test plan
- ADD, result 32'h0000_1234, rd=2:
  - wb_en in E+1 with addr 2, data 16'h1234;
  - done in E+2 with flag_z=0.
- SUB, result 0, rd=5: one write of 16'h0000 to reg 5, then done with flag_z=1.
- MUL, result 32'h0001_E240, rd=7, macro defined:
  - writes 16'hE240 to reg 7, then 16'h0001 to reg 0;
  - flag_ovf=1; done in E+3.
  - With the macro undefined: only the reg 7 write occurs; flag_ovf=1; done in E+2.
- DIV, result 32'hFFFF_FFFF: no wb_en; done in E+1 with flag_dz=1, flag_z=0. Opcode 3'b101 gives the same timing with flag_ill=1.
- Reset and back-pressure:
  - Assert rst_n=0 during the WR_LO cycle of a MUL: next cycle all outputs 0, no WR_HI write, flags cleared.
  - in_valid held high across a transaction: exactly one accept per IDLE visit.
